// File: rtl/bram_led_player.sv
// -----------------------------------------------------------------------------
// bram_led_player
//
// Plays a stored LED pattern sequence out of a block RAM onto the board LEDs.
// A start pulse latches a base address and an entry count. For each entry the
// player issues a single read, waits for the RAM to return the word, drives
// the low LED_W bits onto the LEDs, and holds them for TICK_DIV clock cycles.
// At the end of the range it either restarts from the first entry (loop=1) or
// returns to idle and pulses done. A stop pulse aborts playback at once and
// leaves the LEDs showing their current pattern.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   start      one-cycle pulse, begins playback when idle
//   stop       one-cycle pulse, aborts playback (wins over start)
//   loop       level, restart at the first entry after the last one
//   base_addr  first RAM address, sampled when start is accepted
//   length     number of entries, sampled when start is accepted
//   r_en       RAM read enable (high for exactly one cycle per entry)
//   r_addr     RAM read address (holds its last value between reads)
//   data_in    RAM read data
//   valid_in   RAM read data valid
//   led        LED pattern
//   busy       high while playing
//   done       one-cycle pulse after a normal (non-aborted) completion
//
// State table
//   IDLE  | waiting for an accepted start
//   FETCH | r_en high for one cycle, read issued at base+index
//   WAIT  | waiting for valid_in, no timeout
//   HOLD  | LEDs held for TICK_DIV cycles, then next entry / loop / finish
// -----------------------------------------------------------------------------
module bram_led_player #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int LED_W    = 5,
    parameter int TICK_DIV = 12000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              done
);

    // Hold counter needs to reach TICK_DIV-1; keep at least one bit when
    // TICK_DIV is 1.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  hold_cnt;

    // Only the low LED_W bits of a RAM word reach the pins.
    generate
        if (LED_W < DATA_W) begin : g_unused_hi
            logic unused_data_hi;
            assign unused_data_hi = ^data_in[DATA_W-1:LED_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            index    <= '0;
            hold_cnt <= '0;
            r_en     <= 1'b0;
            r_addr   <= '0;
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // r_en and done are single-cycle strobes; they are re-asserted
            // only on the transitions that need them.
            r_en <= 1'b0;
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !stop && (length != '0)) begin
                        base_q <= base_addr;
                        len_q  <= length;
                        index  <= '0;
                        r_addr <= base_addr;
                        r_en   <= 1'b1;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end

                FETCH: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (stop) begin
                        // The outstanding read is dropped; IDLE ignores valid_in.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (valid_in) begin
                        led      <= data_in[LED_W-1:0];
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                end

                HOLD: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        if (index < (len_q - ADDR_ONE)) begin
                            index  <= index + ADDR_ONE;
                            r_addr <= base_q + index + ADDR_ONE;
                            r_en   <= 1'b1;
                            state  <= FETCH;
                        end else if (loop) begin
                            index  <= '0;
                            r_addr <= base_q;
                            r_en   <= 1'b1;
                            state  <= FETCH;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bram_led_player.md
Name: bram_led_player

Overview:
- Downstream consumer of the implicit block RAM. Plays a stored LED pattern sequence back onto the board LEDs.
- On a start pulse, it walks a contiguous address range, issuing one read per step. It latches each returned word onto the LED outputs and holds it for a programmable number of clock cycles.
- Optionally loops the sequence. Sits between the BRAM read port and the LED pins, replacing direct button-driven reads.

Parameters:
ADDR_W, 8, BRAM address width
DATA_W, 16, BRAM data width
LED_W, 5, number of LEDs driven (LED_W <= DATA_W)
TICK_DIV, 12000000, hold cycles per step (1 s at 12 MHz); legal range >= 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse: begin playback
stop  in  1  one-cycle pulse: abort playback
loop  in  1  level: 1 = restart at first entry after last
base_addr  in  ADDR_W  first BRAM address, sampled on accepted start
length  in  ADDR_W  number of entries, sampled on accepted start
r_en  out  1  BRAM read enable
r_addr  out  ADDR_W  BRAM read address
data_in  in  DATA_W  BRAM data_out
valid_in  in  1  BRAM valid_out
led  out  LED_W  LED pattern, driven as data_in[LED_W-1:0]
busy  out  1  high while playing
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - Reset values: r_en=0, r_addr=0, led=0, busy=0, done=0. State is IDLE, index=0, hold counter=0.
  - Reset mid-playback returns to IDLE next edge with the above values.
- State IDLE:
  - start=1, stop=0 and length!=0 -> latch base_addr, length, index=0; go to FETCH.
  - start with length==0 is ignored.
  - valid_in is ignored.
- State FETCH (exactly 1 cycle): r_en=1, r_addr=base+index (mod 2^ADDR_W, wraps past max address); then go to WAIT.
- State WAIT:
  - r_en=0. Stays until valid_in=1; no timeout.
  - On valid_in: led <= data_in[LED_W-1:0], hold counter=0, go to HOLD.
- State HOLD:
  - Counts TICK_DIV cycles, then exits:
    - if index < length-1: index+1, go to FETCH;
    - else if loop=1: index=0, go to FETCH;
    - else go to IDLE and pulse done.
  - loop is sampled at the last HOLD cycle.
- Latency with 1-cycle BRAM:
  - start sampled at cycle 0; FETCH at cycle 1; WAIT at cycle 2 (valid_in high); led updates at cycle 3.
  - Step period is TICK_DIV+2 cycles.
- busy: 1 in FETCH/WAIT/HOLD, 0 in IDLE.
- done: registered; high for exactly the first IDLE cycle after normal completion.
- r_en: high only in FETCH; r_addr holds its last value otherwise.
- stop:
  - In any non-IDLE state -> IDLE next edge. r_en=0, busy=0, led retains its current value, no done pulse.
  - A read in flight is discarded.
  - stop and start in the same cycle: stop wins, no playback starts.
- start while busy is ignored (no restart, latched params unchanged).
- base_addr and length changes while busy have no effect.
- led changes only on a valid_in captured in WAIT, or on reset.

Test Plan:
- Reset/idle: TICK_DIV=4; assert rst 2 cycles. Then r_en=0, led=0, busy=0, done=0. valid_in pulsed in IDLE with data_in=16'h001F -> led stays 0.
- Single pass: BRAM[10]=5'b11110, BRAM[11]=5'b00001; start with base=10, length=2, loop=0.
  - r_en at cycles 1 and 7, with r_addr 10 then 11.
  - led=11110 at cycle 3 and 00001 at cycle 9.
  - done pulse at cycle 13; busy low from 13.
- Loop and wrap: base=255, length=3, loop=1. r_addr sequence 255,0,1,255,0; clear loop during the third HOLD -> done after address 1 of that pass.
- Stop mid-hold: stop during the second HOLD of the single-pass case. Next cycle busy=0, r_en=0, led holds 00001, done never asserts.
- Edge cases:
  - start with length=0 -> busy stays 0.
  - start and stop in the same cycle -> no FETCH.
  - start pulsed while busy -> sequence and r_addr pattern unchanged.
- Slow BRAM: delay valid_in 3 cycles after r_en. WAIT holds and led updates the cycle after valid_in; step period becomes TICK_DIV+4.
